ibex_instr_bus_arbiter: RTL



---
 rtl/ibex_pkg.sv | 11 +
 rtl/ibex_instr_bus_id_fifo.sv | 58 +++++
 rtl/ibex_instr_bus_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the instruction-bus arbiter: requester IDs and the outstanding-transaction ceiling.
package ibex_pkg;

    typedef enum logic {
        IBUS_PREFETCH  = 1'b0,
        IBUS_SECONDARY = 1'b1
    } ibus_req_id_e;

    localparam int unsigned IBUS_ARB_MAX_OUTSTANDING_MAX = 4;

endpackage

// File: rtl/ibex_instr_bus_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered memory transactions.
module ibex_instr_bus_id_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         push_id_i,
    input  logic                         pop_i,
    output logic                         head_id_o,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    ibus_req_id_e    mem [Depth];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CntW'(Depth));
    assign count_o   = count_q;
    assign head_id_o = mem[rptr_q];

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wptr_q] <= ibus_req_id_e'(push_id_i);
                wptr_q      <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Shares the instruction-memory port between prefetch (port 0) and a secondary fetcher (port 1).
// Define IBEX_IBUS_ARB_RR_EN for round-robin tie-breaking instead of fixed port-0 priority.
module ibex_instr_bus_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_i,
    input  logic [1:0][31:0] addr_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       rvalid_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic             instr_req_o,
    input  logic             instr_gnt_i,
    output logic [31:0]      instr_addr_o,
    input  logic [31:0]      instr_rdata_i,
    input  logic             instr_err_i,
    input  logic             instr_rvalid_i,
    output logic             busy_o,
    output logic             unexp_rvalid_o
);

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_LOCKED = 1'b1;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

    logic            lock_q;
    logic            lock_next;
    ibus_req_id_e    sel_q;
    ibus_req_id_e    sel_next;
    ibus_req_id_e    winner;
    ibus_req_id_e    active_sel;
    logic            head_id;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] count_q;
    logic            issue;
    logic            push;
    logic            pop;
    logic            unexp_q;

`ifdef IBEX_IBUS_ARB_RR_EN
    logic last_q;

    always_comb begin
        if (req_i == 2'b11) begin
            winner = last_q ? IBUS_PREFETCH : IBUS_SECONDARY;
        end else begin
            winner = req_i[0] ? IBUS_PREFETCH : IBUS_SECONDARY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b0;
        end else if (push) begin
            last_q <= active_sel;
        end
    end
`else
    assign winner = req_i[0] ? IBUS_PREFETCH : IBUS_SECONDARY;
`endif

    // A locked request never needs a free slot: the count only grows on its grant.
    assign issue       = (lock_q == STATE_IDLE) && !fifo_full && (req_i != 2'b00);
    assign instr_req_o = (lock_q == STATE_LOCKED) || issue;
    assign active_sel  = (lock_q == STATE_LOCKED) ? sel_q : winner;
    assign instr_addr_o = {addr_i[active_sel][31:2], 2'b00};

    assign push = instr_req_o && instr_gnt_i;
    assign pop  = instr_rvalid_i && !fifo_empty;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_o[gi]    = push && (active_sel == 1'(gi));
            assign rvalid_o[gi] = pop && (head_id == 1'(gi));
        end
    endgenerate

    assign rdata_o        = instr_rdata_i;
    assign err_o          = instr_err_i;
    assign busy_o         = (count_q != '0) || instr_req_o;
    assign unexp_rvalid_o = unexp_q;

    always_comb begin
        lock_next = lock_q;
        sel_next  = sel_q;
        if (lock_q == STATE_IDLE) begin
            if (issue && !instr_gnt_i) begin
                lock_next = STATE_LOCKED;
                sel_next  = winner;
            end
        end else if (instr_gnt_i) begin
            lock_next = STATE_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q  <= STATE_IDLE;
            sel_q   <= IBUS_PREFETCH;
            unexp_q <= 1'b0;
        end else begin
            lock_q  <= lock_next;
            sel_q   <= sel_next;
            unexp_q <= unexp_q || (instr_rvalid_i && fifo_empty);
        end
    end

    ibex_instr_bus_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .push_id_i (active_sel),
        .pop_i     (pop),
        .head_id_o (head_id),
        .count_o   (count_q),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

endmodule
